// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        CORE  = 1'b0,
        DEBUG = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        RR    = 2'd0,
        LOCK  = 2'd1,
        YIELD = 2'd2
    } arb_state_t;

    localparam int PERF_W = 16;

endpackage

// File: rtl/dmem_arb_perf.sv
// Saturating conflict / core-stall event counters; 1-cycle update latency.
// No backpressure: counts whatever event strobes it is given every cycle.
import dmem_arb_pkg::*;

module dmem_arb_perf (
    input  logic              clk,
    input  logic              reset,
    input  logic              conflict,
    input  logic              core_stall,
    output logic [PERF_W-1:0] perf_conflicts,
    output logic [PERF_W-1:0] perf_core_stall
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conflicts  <= '0;
            perf_core_stall <= '0;
        end else begin
            if (conflict && (perf_conflicts != {PERF_W{1'b1}}))
                perf_conflicts <= perf_conflicts + 1'b1;
            if (core_stall && (perf_core_stall != {PERF_W{1'b1}}))
                perf_core_stall <= perf_core_stall + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core / debug arbiter for the single dmem port: round-robin with bounded debug lock bursts.
// Grant is combinational (0 cycles), read data returns 1 cycle after grant; losers simply wait.
// Optional perf counters when DMEM_ARB_PERF_EN is defined.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_conflicts,
    output logic [PERF_W-1:0] perf_core_stall
`endif
);

    localparam int              CNT_W      = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

    arb_state_t       state, state_nx;
    owner_t           last;
    owner_t           rr_pick, win;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;
    logic             any_req;

    assign any_req = c_req | d_req;

    always_comb begin
        rr_pick = (last == DEBUG) ? CORE : DEBUG;
        if (c_req && !d_req)
            rr_pick = CORE;
        else if (d_req && !c_req)
            rr_pick = DEBUG;
    end

    // Lock only overrides RR while debug keeps both req and lock up; otherwise RR rules apply this cycle.
    always_comb begin
        win = rr_pick;
        case (state)
            LOCK:    if (d_req && d_lock) win = DEBUG;
            YIELD:   win = c_req ? CORE : DEBUG;
            default: ;
        endcase
    end

    assign c_gnt = any_req && (win == CORE);
    assign d_gnt = any_req && (win == DEBUG);

    assign m_we    = (c_gnt & c_we) | (d_gnt & d_we);
    assign m_addr  = c_gnt ? c_addr  : (d_gnt ? d_addr  : '0);
    assign m_wdata = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = burst_cnt;
        case (state)
            RR: begin
                if (d_gnt && d_lock) begin
                    cnt_nx   = CNT_W'(1);
                    state_nx = (BURST_MAX == 1) ? YIELD : LOCK;
                end
            end
            LOCK: begin
                if (d_req && d_lock) begin
                    cnt_nx   = burst_cnt + 1'b1;
                    state_nx = (cnt_nx == BURST_LAST) ? YIELD : LOCK;
                end else begin
                    cnt_nx   = '0;
                    state_nx = RR;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = RR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RR;
            last      <= DEBUG;
            burst_cnt <= '0;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            c_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= cnt_nx;
            if (c_gnt)
                last <= CORE;
            else if (d_gnt)
                last <= DEBUG;
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_gnt && !c_we)
                c_rdata <= m_rdata;
            if (d_gnt && !d_we)
                d_rdata <= m_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf u_perf (
        .clk             (clk),
        .reset           (reset),
        .conflict        (c_req & d_req),
        .core_stall      (c_req & ~c_gnt),
        .perf_conflicts  (perf_conflicts),
        .perf_core_stall (perf_core_stall)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against a rule-level arbitration and memory model.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BMAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   perf_conflicts, perf_core_stall;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_core_stall(perf_core_stall)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side memory: combinational read, write on the edge ending the grant cycle.
    logic [DW-1:0] mem [64];
    assign m_rdata = mem[m_addr[7:2]];
    always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    int            lock_run, stall_run, max_stall, perf_conf, perf_stall;
    bit            yield_pend, last_dbg, exp_crv, exp_drv, g_c, g_d;
    logic [DW-1:0] exp_crd, exp_drd;
    int            n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lock_run = 0; yield_pend = 0; last_dbg = 1;
        exp_crv = 0; exp_drv = 0; exp_crd = '0; exp_drd = '0;
        perf_conf = 0; perf_stall = 0; stall_run = 0;
    endtask

    // Check one cycle (inputs already driven at the falling edge), then advance the model.
    task automatic cycle();
        bit ec, ed;
        #1;
        ec = 0; ed = 0;
        if (yield_pend) begin
            ec = c_req; ed = !c_req && d_req;
        end else if (lock_run > 0 && d_req && d_lock) begin
            ed = 1;
        end else if (c_req && d_req) begin
            ec = last_dbg; ed = !last_dbg;
        end else begin
            ec = c_req; ed = d_req;
        end
        chk("c_gnt", c_gnt, ec);
        chk("d_gnt", d_gnt, ed);
        chk("m_we", m_we, (ec && c_we) || (ed && d_we));
        chk("m_addr", m_addr, ec ? c_addr : (ed ? d_addr : '0));
        chk("m_wdata", m_wdata, ec ? c_wdata : (ed ? d_wdata : '0));
        chk("c_rvalid", c_rvalid, exp_crv);
        chk("c_rdata", c_rdata, exp_crd);
        chk("d_rvalid", d_rvalid, exp_drv);
        chk("d_rdata", d_rdata, exp_drd);
        exp_crv = ec && !c_we;
        exp_drv = ed && !d_we;
        if (exp_crv) exp_crd = ref_mem[c_addr[7:2]];
        if (exp_drv) exp_drd = ref_mem[d_addr[7:2]];
        if (ec && c_we) ref_mem[c_addr[7:2]] = c_wdata;
        if (ed && d_we) ref_mem[d_addr[7:2]] = d_wdata;
        if (c_req && d_req && perf_conf < 16'hFFFF) perf_conf++;
        if (c_req && !ec && perf_stall < 16'hFFFF) perf_stall++;
        if (c_req && !ec) stall_run++; else stall_run = 0;
        if (stall_run > max_stall) max_stall = stall_run;
        if (yield_pend) begin
            yield_pend = 0; lock_run = 0;
        end else if (ed && d_lock) begin
            lock_run++;
            if (lock_run == BMAX) begin yield_pend = 1; lock_run = 0; end
        end else begin
            lock_run = 0;
        end
        if (ec) last_dbg = 0;
        else if (ed) last_dbg = 1;
        g_c = ec; g_d = ed;
    endtask

    task automatic set_c(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w);
        c_req = req; c_we = we; c_addr = a; c_wdata = w;
    endtask

    task automatic set_d(input bit req, input bit we, input bit lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] w);
        d_req = req; d_we = we; d_lock = lk; d_addr = a; d_wdata = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [11:0] dpat;
        logic [5:0]  cpat;
        logic [DW-1:0] keep;
        bit cp, dp, lock_mode;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        end
        max_stall = 0;
        reset = 1'b0;
        set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0);
        model_reset();

        // Reset state
        @(negedge clk); cycle();
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        @(negedge clk); reset = 1'b1;

        // Core-only write then read
        @(negedge clk); set_c(1, 1, 32'h10, 32'hDEADBEEF); cycle();
        @(negedge clk); set_c(1, 0, 32'h10, '0); cycle();
        chk("core_rd_gnt", c_gnt, 1);
        @(negedge clk); set_c(0, 0, '0, '0); cycle();
        chk("core_rd_data", c_rdata, 32'hDEADBEEF);
        chk("core_rd_valid", c_rvalid, 1);

        // Conflict after reset: core first, debug next
        do_reset();
        @(negedge clk); set_c(1, 0, 32'h4, '0); set_d(1, 0, 0, 32'h8, '0); cycle();
        chk("conf_first_core", c_gnt, 1);
        @(negedge clk); set_c(0, 0, '0, '0); cycle();
        chk("conf_then_dbg", d_gnt, 1);
        @(negedge clk); set_d(0, 0, 0, '0, '0); cycle();
        chk("conf_d_data", d_rdata, mem[2]);

        // Sustained conflict for 6 cycles
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); set_c(1, 0, 32'h20, '0); set_d(1, 0, 0, 32'h24, '0); cycle();
            cpat[5-i] = c_gnt;
        end
        chk("sustained_pattern", cpat, 6'b101010);
        @(negedge clk); set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0); cycle();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflicts_6", perf_conflicts, 6);
        chk("perf_core_stall_3", perf_core_stall, 3);
`endif

        // Locked burst: make core the last owner, then lock for 12 cycles against core traffic
        @(negedge clk); set_c(1, 1, 32'h30, 32'h0BADF00D); cycle();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); set_c(1, 0, 32'h34, '0); set_d(1, 0, 1, 32'h38, '0); cycle();
            dpat[11-i] = d_gnt;
        end
        chk("lock_pattern", dpat, 12'b1111_1111_0111);
        @(negedge clk); set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0); cycle();

        // Reset asserted in the cycle of a debug read grant
        @(negedge clk); set_d(1, 0, 0, 32'h8, '0); cycle();
        chk("rstmid_grant", d_gnt, 1);
        reset = 1'b0;
        set_d(0, 0, 0, '0, '0);
        model_reset();
        @(negedge clk); cycle();
        chk("rstmid_no_rvalid", d_rvalid, 0);
        @(negedge clk); reset = 1'b1;
        set_c(1, 0, 32'h4, '0); set_d(1, 0, 0, 32'h8, '0); cycle();
        chk("rstmid_core_first", c_gnt, 1);

        // Abandoned debug write while core owns the port
        do_reset();
        keep = mem[8];
        @(negedge clk); set_c(1, 0, 32'h40, '0); set_d(1, 1, 0, 32'h20, 32'h12345678); cycle();
        chk("abandon_no_dgnt", d_gnt, 0);
        @(negedge clk); set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0); cycle();
        @(negedge clk); cycle();
        chk("abandon_mem", mem[8], keep);

        // Random traffic
        cp = 0; dp = 0; lock_mode = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!cp) begin
                if ($urandom_range(0, 99) < 65) begin
                    cp = 1;
                    set_c(1, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                cp = 0;
            end
            c_req = cp;
            if ($urandom_range(0, 99) < 8) lock_mode = !lock_mode;
            if (!dp) begin
                if ($urandom_range(0, 99) < (lock_mode ? 90 : 50)) begin
                    dp = 1;
                    set_d(1, 1'($urandom_range(0, 1)), lock_mode, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                dp = 0;
            end
            d_req = dp;
            d_lock = lock_mode;
            cycle();
            if (g_c) cp = 0;
            if (g_d) dp = 0;
        end
        @(negedge clk); set_c(0, 0, '0, '0); set_d(0, 0, 0, '0, '0); cycle();
        chk("max_core_stall", max_stall <= BMAX, 1);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflicts_rand", perf_conflicts, perf_conf);
        chk("perf_core_stall_rand", perf_core_stall, perf_stall);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
